blade_fader: RTL and testbench

// - Per-LED PWM fade stage between the trail pattern generator and the blade pins.
// - Loads full brightness for each LED whose pattern bit is set.
// - Decays every LED's brightness geometrically on a slow tick, giving the trail a fading comet tail.
// - Drives blade_leds directly. Runs from the 25 MHz board clock.

---
 rtl/blade_fader.sv | 84 ++++++++
 tb/tb_blade_fader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/blade_fader.sv
// Per-LED PWM fade stage: pattern strobes load full brightness, a slow tick decays it geometrically.
// Optional BLADE_FADER_GAMMA_EN adds a registered square-law duty correction stage.
module blade_fader #(
  parameter int unsigned N_LEDS      = 6,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DECAY_DIV   = 250000,
  parameter int unsigned DECAY_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic              pattern_valid,
  output logic [N_LEDS-1:0] blade_leds,
  output logic              frame_tick
);

  localparam int unsigned PS_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PS_W-1:0]     prescaler;
  logic                decay_tick;
  logic [PWM_BITS-1:0] level     [N_LEDS];
  logic [PWM_BITS-1:0] level_nxt [N_LEDS];
  logic [PWM_BITS-1:0] step      [N_LEDS];
  logic [PWM_BITS-1:0] duty      [N_LEDS];

  assign decay_tick = (prescaler == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt    <= '0;
      prescaler  <= '0;
      frame_tick <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      prescaler  <= decay_tick ? '0 : prescaler + 1'b1;
      frame_tick <= (pwm_cnt == LVL_MAX);
    end
  end

  // Step is at least 1 and never exceeds a nonzero level, so decay cannot wrap.
  always_comb begin
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      step[i] = level[i] >> DECAY_SHIFT;
      if (step[i] == '0) step[i] = PWM_BITS'(1);
      level_nxt[i] = level[i];
      if (pattern_valid && pattern_in[i])
        level_nxt[i] = LVL_MAX;
      else if (decay_tick && (level[i] != '0))
        level_nxt[i] = level[i] - step[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (rst) level[i] <= '0;
      else     level[i] <= level_nxt[i];
    end
  end

`ifdef BLADE_FADER_GAMMA_EN
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (rst) duty[i] <= '0;
      else     duty[i] <= PWM_BITS'(({{PWM_BITS{1'b0}}, level[i]} *
                                     {{PWM_BITS{1'b0}}, level[i]}) >> PWM_BITS);
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < N_LEDS; i++) duty[i] = level[i];
  end
`endif

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (rst) blade_leds[i] <= 1'b0;
      else     blade_leds[i] <= (duty[i] > pwm_cnt);
    end
  end

endmodule

// File: tb/tb_blade_fader.sv
// Directed self-checking bench for blade_fader (linear or BLADE_FADER_GAMMA_EN build).
module tb_blade_fader;

  logic       clk = 1'b0;
  logic       rst, rst2, pv, pv2;
  logic [5:0] pin, pin2, leds, leds2;
  logic       ft, ft2;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  blade_fader #(.N_LEDS(6), .PWM_BITS(8), .DECAY_DIV(16), .DECAY_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .pattern_in(pin), .pattern_valid(pv),
    .blade_leds(leds), .frame_tick(ft)
  );

  // Slow-decay instance so a level stays constant across whole PWM frames.
  blade_fader #(.N_LEDS(6), .PWM_BITS(8), .DECAY_DIV(2048), .DECAY_SHIFT(2)) dut2 (
    .clk(clk), .rst(rst2), .pattern_in(pin2), .pattern_valid(pv2),
    .blade_leds(leds2), .frame_tick(ft2)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_levels_zero(input string tag);
    for (int i = 0; i < 6; i++) check(tag, int'(dut.level[i]), 0);
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (ft !== 1'b1 && n < 300) begin tick(); n++; end
    check(tag, int'(ft === 1'b1), 1);
  endtask

  int dec_exp [20] = '{192, 144, 108, 81, 61, 46, 35, 27, 21, 16,
                       12, 9, 7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, prev, hi, other;
    rst = 1'b1; rst2 = 1'b1; pv = 1'b1; pin = 6'h3F; pv2 = 1'b0; pin2 = '0;

    // Reset dominates a concurrent strobe
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_leds", int'(leds), 0);
      check("rst_ftick", int'(ft), 0);
    end
    rst = 1'b0; pv = 1'b0; pin = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_levels_zero("rst_level");
      check("rst_leds_post", int'(leds), 0);
    end

    // Load latency, aligned just after a frame start (pwm_cnt small)
    wait_frame("wait_frame0");
    pv = 1'b1; pin = 6'b000001;
    tick();
    pv = 1'b0; pin = '0;
    check("load_level0", int'(dut.level[0]), 255);
    check("load_leds_t1", int'(leds[0]), 0);
    tick();
`ifdef BLADE_FADER_GAMMA_EN
    check("load_leds_t2", int'(leds[0]), 0);
`else
    check("load_leds_t2", int'(leds[0]), 1);
`endif
    check("load_others", int'(leds[5:1]), 0);
    tick();
    check("load_leds_t3", int'(leds[0]), 1);
    check("load_level1", int'(dut.level[1]), 0);

    n = 0;
    while (dut.level[0] != 0 && n < 500) begin tick(); n++; end
    check("drain", int'(dut.level[0]), 0);

    // Full decay sequence with 16-cycle tick spacing
    pv = 1'b1; pin = 6'b000001;
    tick();
    pv = 1'b0; pin = '0;
    check("dec_load", int'(dut.level[0]), 255);
    prev = 255;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while (int'(dut.level[0]) == prev && n < 40) begin tick(); n++; end
      check($sformatf("dec_val%0d", k), int'(dut.level[0]), dec_exp[k]);
      if (k > 0) check($sformatf("dec_gap%0d", k), n, 16);
      prev = int'(dut.level[0]);
    end
    for (int c = 0; c < 3; c++) tick();
    hi = 0;
    for (int c = 0; c < 64; c++) begin tick(); if (leds[0]) hi++; end
    check("zero_leds_hi", hi, 0);
    check("zero_stays", int'(dut.level[0]), 0);

    // Load on the same edge as a decay tick
    pv = 1'b1; pin = 6'b000011;
    tick();
    pv = 1'b0; pin = '0;
    n = 0;
    while (dut.level[0] != 144 && n < 60) begin tick(); n++; end
    check("col_reach", int'(dut.level[0]), 144);
    for (int c = 0; c < 15; c++) tick();
    check("col_pre1", int'(dut.level[1]), 144);
    pv = 1'b1; pin = 6'b000001;
    tick();
    pv = 1'b0; pin = '0;
    check("col_level0", int'(dut.level[0]), 255);
    check("col_level1", int'(dut.level[1]), 108);

    // Mid-frame reset at pwm_cnt = 130
    wait_frame("wait_frame1");
    pv = 1'b1; pin = 6'h3F;
    tick();
    pv = 1'b0; pin = '0;
    for (int c = 0; c < 129; c++) tick();
    check("mid_pwm", int'(dut.pwm_cnt), 130);
    check("mid_nonzero", int'(dut.level[5] != 0), 1);
    rst = 1'b1;
    tick();
    check_levels_zero("mid_level");
    check("mid_pwm_rst", int'(dut.pwm_cnt), 0);
    rst = 1'b0;
    tick();
    check("mid_leds", int'(leds), 0);
    n = 1;
    while (ft !== 1'b1 && n < 300) begin tick(); n++; end
    check("ftick_first", n, 256);
    tick();
    check("ftick_pulse", int'(ft), 0);
    n = 1;
    while (ft !== 1'b1 && n < 300) begin tick(); n++; end
    check("ftick_period", n, 256);

    // Duty per frame on the slow instance
    tick();
    rst2 = 1'b0;
    pv2 = 1'b1; pin2 = 6'b000001;
    tick();
    pv2 = 1'b0; pin2 = '0;
    check("duty_load", int'(dut2.level[0]), 255);
    for (int c = 0; c < 8; c++) tick();
    hi = 0; other = 0;
    for (int c = 0; c < 256; c++) begin
      tick();
      if (leds2[0]) hi++;
      if (leds2[5:1] != 0) other++;
    end
`ifdef BLADE_FADER_GAMMA_EN
    check("duty_255", hi, 254);
`else
    check("duty_255", hi, 255);
`endif
    check("duty_others", other, 0);
    n = 0;
    while (dut2.level[0] != 61 && n < 13000) begin tick(); n++; end
    check("duty_reach61", int'(dut2.level[0]), 61);
    for (int c = 0; c < 8; c++) tick();
    hi = 0;
    for (int c = 0; c < 256; c++) begin tick(); if (leds2[0]) hi++; end
`ifdef BLADE_FADER_GAMMA_EN
    check("duty_61", hi, 14);
`else
    check("duty_61", hi, 61);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
